free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter FL_DEPTH, default 64: entries in the circular free-tag buffer; pointers 6 bits.
REQ-002 Parameter FL_INIT_BASE, default 32: first free physical tag after reset; PRs 0..31 hold architectural state.
REQ-003 clock  input  1  single clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_dispatch_num  input  2  tags consumed this cycle; 2'b11 is treated as 2.
REQ-006 rob_retire_num  input  2  tags returned this cycle; 2'b11 is treated as 2.
REQ-007 rob_retire_tag_a  input  7  first returned tag, valid when rob_retire_num>=1.
REQ-008 rob_retire_tag_b  input  7  second returned tag, valid when rob_retire_num==2.
REQ-009 id_pr0  output  7  tag for dispatch slot 0; 7'h7f when none available.
REQ-010 id_pr1  output  7  tag for dispatch slot 1; 7'h7f when fewer than 2 available.
REQ-011 id_cap  output  2  tags available this cycle: 0, 1 or 2.
REQ-012 fl_overflow  output  1  sticky error: a returned tag was dropped because the buffer was full.

Function
REQ-013 State: entry[0..FL_DEPTH-1] of 7 bits, head, tail (6 bits, wrap 63->0), count (7 bits, 0..64).
REQ-014 id_pr0 = entry[head], id_pr1 = entry[head+1 mod 64]; both combinational, same cycle as id_dispatch_num.
REQ-015 id_cap = 2 if count>=2, 1 if count==1, 0 if count==0.
REQ-016 Effective dispatch d = min(id_dispatch_num, id_cap); head advances by d with wrap (62+2 -> 0, 63+2 -> 1).
REQ-017 Effective retire r = rob_retire_num; tag_a is written at tail, tag_b at tail+1; tail advances by the tags written.
REQ-018 Returned tags become visible on id_pr* no earlier than the next cycle, unless FL_BYPASS_EN (REQ-026).
REQ-019 count_next = count - d + r (written tags only); dispatch and retire in the same cycle are both honoured.
REQ-020 A write whose slot would bring count above 64 (after subtracting d) is dropped; tail does not advance for it; fl_overflow sets to 1 and holds until reset.
REQ-021 Dispatch exceeding id_cap is clamped; no underflow; count never negative.
REQ-022 No tag-value filtering: 7'h7f returned with nonzero rob_retire_num is stored as-is.

Reset
REQ-023 On reset: entry[i] = FL_INIT_BASE+i, head = 0, tail = 0, count = 64, fl_overflow = 0.
REQ-024 Reset dominates: dispatch/retire inputs in a reset cycle are ignored; first post-reset cycle shows id_pr0=32, id_pr1=33, id_cap=2.
REQ-025 Reset mid-operation discards all in-flight tag state regardless of count.

Configuration
REQ-026 FL_BYPASS_EN defined: available sequence = buffer entries from head, then rob_retire_tag_a, then rob_retire_tag_b; id_cap = min(2, count+r); id_pr0/id_pr1 are the first two of that sequence; bypassed tags consumed by dispatch are not written to the buffer.
REQ-027 FL_BYPASS_EN undefined: REQ-015/REQ-018 apply strictly; no same-cycle forwarding.

Verification
REQ-028 Reset, then id_dispatch_num=2 for 3 cycles -> id_pr0/id_pr1 = 32/33, 34/35, 36/37; count 58 after.
REQ-029 Drain to count=1, id_dispatch_num=2 -> id_cap=1, id_pr1=7'h7f, head advances 1, count 0, next cycle id_cap=0, id_pr0=7'h7f.
REQ-030 count=0, rob_retire_num=2 tags 5/9 with id_dispatch_num=2 -> without FL_BYPASS_EN: id_cap=0 that cycle, next cycle id_pr0=5,id_pr1=9; with FL_BYPASS_EN: id_pr0=5,id_pr1=9,id_cap=2 same cycle, count stays 0.
REQ-031 head=63,tail=62, count=63, dispatch 2 and retire 2 -> head=1, tail=0, count 63, order preserved across wrap.
REQ-032 After reset (count=64), rob_retire_num=1 tag 7'd3, no dispatch -> tag dropped, count 64, fl_overflow=1 and stays 1 until reset.
REQ-033 Any count, id_dispatch_num=2'b11 and rob_retire_num=2'b11 -> behaves exactly as 2 and 2.

Source files
------------

// File: rtl/free_list.sv
// Free list of physical register tags: circular buffer handing out up to 2 tags per cycle.
// Latency: tags on id_pr0/id_pr1 are combinational from head; retired tags become visible next cycle (same cycle with FL_BYPASS_EN).
// Backpressure: dispatch is clamped to id_cap; returned tags that do not fit are dropped and fl_overflow sticks high.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   id_dispatch_num[1:0]         tags consumed this cycle (3 treated as 2)
//   rob_retire_num[1:0]          tags returned this cycle (3 treated as 2)
//   rob_retire_tag_a/_b[6:0]     returned tags, a written first
//   id_pr0/id_pr1[6:0]           next two free tags, 7'h7f when not available
//   id_cap[1:0]                  number of tags available this cycle (0..2)
//   fl_overflow                  sticky: a returned tag was dropped
// Optional feature: define FL_BYPASS_EN to forward returned tags to dispatch in the same cycle.
module free_list #(
    parameter int FL_DEPTH     = 64,
    parameter int FL_INIT_BASE = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] id_dispatch_num,
    input  logic [1:0] rob_retire_num,
    input  logic [6:0] rob_retire_tag_a,
    input  logic [6:0] rob_retire_tag_b,
    output logic [6:0] id_pr0,
    output logic [6:0] id_pr1,
    output logic [1:0] id_cap,
    output logic       fl_overflow
);

    localparam int PTR_W = $clog2(FL_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [6:0] NO_TAG = 7'h7f;

    logic [6:0]       entry_q [FL_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [1:0]       disp_n, ret_n;
    logic [1:0]       buf_cap;      // tags held in the buffer, saturated at 2
    logic [1:0]       d;            // effective dispatch
    logic [1:0]       d_buf;        // part of d taken from the buffer
    logic [1:0]       wr_req;       // returned tags that still need a buffer slot
    logic [1:0]       wr_n;         // returned tags actually written
    logic [6:0]       wr0, wr1;     // data for slots tail and tail+1
    logic [6:0]       buf0, buf1;
    logic [CNT_W-1:0] space;
`ifdef FL_BYPASS_EN
    logic [CNT_W:0]   avail;
    logic [1:0]       d_byp;
`endif

    always_comb begin
        disp_n  = (id_dispatch_num == 2'b11) ? 2'd2 : id_dispatch_num;
        ret_n   = (rob_retire_num == 2'b11) ? 2'd2 : rob_retire_num;
        buf0    = entry_q[head_q];
        buf1    = entry_q[head_q + PTR_W'(1)];
        buf_cap = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];

        id_pr0  = NO_TAG;
        id_pr1  = NO_TAG;
        id_cap  = 2'd0;
        d       = 2'd0;
        d_buf   = 2'd0;
        wr_req  = 2'd0;
        wr0     = rob_retire_tag_a;
        wr1     = rob_retire_tag_b;
`ifdef FL_BYPASS_EN
        // Available sequence: buffer entries from head, then tag_a, then tag_b.
        avail = {1'b0, count_q} + (CNT_W+1)'(ret_n);
        d_byp = 2'd0;
        id_cap = (avail >= (CNT_W+1)'(2)) ? 2'd2 : avail[1:0];
        if (count_q >= CNT_W'(1))
            id_pr0 = buf0;
        else if (ret_n >= 2'd1)
            id_pr0 = rob_retire_tag_a;
        if (count_q >= CNT_W'(2))
            id_pr1 = buf1;
        else if (count_q == CNT_W'(1)) begin
            if (ret_n >= 2'd1)
                id_pr1 = rob_retire_tag_a;
        end else if (ret_n == 2'd2)
            id_pr1 = rob_retire_tag_b;
        d     = (disp_n > id_cap) ? id_cap : disp_n;
        d_buf = (d > buf_cap) ? buf_cap : d;
        d_byp = d - d_buf;
        // Forwarded tags are consumed and never reach the buffer.
        case (d_byp)
            2'd0: wr_req = ret_n;
            2'd1: begin
                wr_req = ret_n - 2'd1;
                wr0    = rob_retire_tag_b;
            end
            default: wr_req = 2'd0;
        endcase
`else
        id_cap = buf_cap;
        if (count_q >= CNT_W'(1))
            id_pr0 = buf0;
        if (count_q >= CNT_W'(2))
            id_pr1 = buf1;
        d      = (disp_n > id_cap) ? id_cap : disp_n;
        d_buf  = d;
        wr_req = ret_n;
`endif
        // Room left after this cycle's dispatch; writes beyond it are dropped.
        space = CNT_W'(FL_DEPTH) - (count_q - CNT_W'(d_buf));
        if (space >= CNT_W'(2))
            wr_n = wr_req;
        else if (space == CNT_W'(1))
            wr_n = (wr_req != 2'd0) ? 2'd1 : 2'd0;
        else
            wr_n = 2'd0;

        head_d  = head_q + PTR_W'(d_buf);
        tail_d  = tail_q + PTR_W'(wr_n);
        count_d = count_q - CNT_W'(d_buf) + CNT_W'(wr_n);
        ovf_d   = ovf_q | (wr_n != wr_req);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                entry_q[i] <= 7'(FL_INIT_BASE + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_DEPTH);
            ovf_q   <= 1'b0;
        end else begin
            if (wr_n >= 2'd1)
                entry_q[tail_q] <= wr0;
            if (wr_n == 2'd2)
                entry_q[tail_q + PTR_W'(1)] <= wr1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fl_overflow = ovf_q;

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] id_dispatch_num;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_retire_tag_a;
    logic [6:0] rob_retire_tag_b;
    logic [6:0] id_pr0;
    logic [6:0] id_pr1;
    logic [1:0] id_cap;
    logic       fl_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    free_list dut (
        .clock           (clock),
        .reset           (reset),
        .id_dispatch_num (id_dispatch_num),
        .rob_retire_num  (rob_retire_num),
        .rob_retire_tag_a(rob_retire_tag_a),
        .rob_retire_tag_b(rob_retire_tag_b),
        .id_pr0          (id_pr0),
        .id_pr1          (id_pr1),
        .id_cap          (id_cap),
        .fl_overflow     (fl_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Commit the current inputs at the next rising edge, return 1 time unit later.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] dn, input logic [1:0] rn,
                         input logic [6:0] ta, input logic [6:0] tb);
        id_dispatch_num  = dn;
        rob_retire_num   = rn;
        rob_retire_tag_a = ta;
        rob_retire_tag_b = tb;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        // Activity during reset must be ignored.
        drive(2'd2, 2'd2, 7'd11, 7'd12);
        tick;
        tick;
        reset = 1'b0;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        do_reset;

        // Reset state
        chk("rst_pr0", id_pr0, 32);
        chk("rst_pr1", id_pr1, 33);
        chk("rst_cap", id_cap, 2);
        chk("rst_ovf", fl_overflow, 0);
        chk("rst_count", dut.count_q, 64);

        // Return into a full buffer: dropped, overflow sticks
        drive(2'd0, 2'd1, 7'd3, 7'd0);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("ovf_set", fl_overflow, 1);
        chk("ovf_count", dut.count_q, 64);
        chk("ovf_tail", dut.tail_q, 0);
        chk("ovf_pr0", id_pr0, 32);

        // Three double dispatches
        for (int k = 0; k < 3; k++) begin
            drive(2'd2, 2'd0, 7'd0, 7'd0);
            chk("disp_pr0", id_pr0, 32 + 2 * k);
            chk("disp_pr1", id_pr1, 33 + 2 * k);
            tick;
        end
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("disp_count", dut.count_q, 58);
        chk("ovf_hold", fl_overflow, 1);

        // Dispatch code 3 acts as 2
        drive(2'd3, 2'd0, 7'd0, 7'd0);
        chk("d3_pr0", id_pr0, 38);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("d3_count", dut.count_q, 56);
        chk("d3_head", dut.head_q, 8);

        // Drain to a single entry
        for (int k = 0; k < 27; k++) begin
            drive(2'd2, 2'd0, 7'd0, 7'd0);
            chk("drain_pr0", id_pr0, 40 + 2 * k);
            tick;
        end
        drive(2'd1, 2'd0, 7'd0, 7'd0);
        chk("drain_pr0_last2", id_pr0, 94);
        tick;
        drive(2'd2, 2'd0, 7'd0, 7'd0);
        chk("one_cap", id_cap, 1);
        chk("one_pr0", id_pr0, 95);
        chk("one_pr1", id_pr1, 7'h7f);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("empty_cap", id_cap, 0);
        chk("empty_pr0", id_pr0, 7'h7f);
        chk("empty_pr1", id_pr1, 7'h7f);
        chk("empty_count", dut.count_q, 0);
        chk("empty_head", dut.head_q, 0);

        // Dispatch on empty is clamped
        drive(2'd2, 2'd0, 7'd0, 7'd0);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("clamp_count", dut.count_q, 0);
        chk("clamp_head", dut.head_q, 0);

        // Return 5/9 into empty list while dispatching 2
        drive(2'd2, 2'd2, 7'd5, 7'd9);
`ifdef FL_BYPASS_EN
        chk("byp_cap", id_cap, 2);
        chk("byp_pr0", id_pr0, 5);
        chk("byp_pr1", id_pr1, 9);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("byp_count", dut.count_q, 0);
        chk("byp_tail", dut.tail_q, 0);
`else
        chk("ret_cap_same", id_cap, 0);
        chk("ret_pr0_same", id_pr0, 7'h7f);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("ret_pr0_next", id_pr0, 5);
        chk("ret_pr1_next", id_pr1, 9);
        chk("ret_cap_next", id_cap, 2);
        chk("ret_count", dut.count_q, 2);
`endif

        // Mid-operation reset clears overflow and restores the initial tags
        do_reset;
        chk("rst2_pr0", id_pr0, 32);
        chk("rst2_cap", id_cap, 2);
        chk("rst2_ovf", fl_overflow, 0);
        chk("rst2_count", dut.count_q, 64);

        // Walk to head=63, tail=62, count=63
        drive(2'd1, 2'd0, 7'd0, 7'd0);
        tick;
        for (int k = 0; k < 62; k++) begin
            drive(2'd1, 2'd1, 7'(k), 7'd0);
            tick;
        end
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("wrap_head0", dut.head_q, 63);
        chk("wrap_tail0", dut.tail_q, 62);
        chk("wrap_count0", dut.count_q, 63);
        chk("wrap_ovf0", fl_overflow, 0);

        // Dispatch 2 / retire code 3 across the wrap point
        drive(2'd3, 2'd3, 7'd120, 7'd121);
        chk("wrap_pr0", id_pr0, 95);
        chk("wrap_pr1", id_pr1, 0);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("wrap_head", dut.head_q, 1);
        chk("wrap_tail", dut.tail_q, 0);
        chk("wrap_count", dut.count_q, 63);
        chk("wrap_ovf", fl_overflow, 0);

        // Order preserved: 1..61 then 120, 121
        for (int k = 0; k < 30; k++) begin
            drive(2'd2, 2'd0, 7'd0, 7'd0);
            chk("order_pr0", id_pr0, 1 + 2 * k);
            tick;
        end
        drive(2'd2, 2'd0, 7'd0, 7'd0);
        chk("order_tail_pr0", id_pr0, 61);
        chk("order_tail_pr1", id_pr1, 120);
        tick;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        chk("order_last_pr0", id_pr0, 121);
        chk("order_last_pr1", id_pr1, 7'h7f);
        chk("order_last_cap", id_cap, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
